// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - FFT32 output reorder, bit-reversed to natural order via ping-pong banks; optional FFT_REORDER_BYPASS_EN
module fft_out_reorder #(
    parameter int NB  = 16,
    parameter int NPT = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid_i,
    input  logic          in_start_i,
`ifdef FFT_REORDER_BYPASS_EN
    input  logic          bypass_i,
`endif
    input  logic [NB-1:0] DR,
    input  logic [NB-1:0] DI,
    output logic          out_valid_o,
    output logic          out_start_o,
    output logic [NB-1:0] OR,
    output logic [NB-1:0] OI
);

    localparam int AW = 5;
    localparam logic [AW-1:0] LAST = AW'(NPT - 1);

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } r_state_t;

    function automatic logic [AW-1:0] bitrev5(input logic [AW-1:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    // Two banks of NPT {DR,DI} words; bank select is the address MSB.
    logic [2*NB-1:0] mem [0:2*NPT-1];

    w_state_t        w_state;
    w_state_t        w_state_nx;
    logic            w_bank;
    logic [AW-1:0]   w_ptr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            frame_done;

    r_state_t        r_state;
    r_state_t        r_state_nx;
    logic            r_bank;
    logic            r_bank_nx;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_cnt_nx;
    logic [1:0]      full;
    logic [1:0]      full_nx;
    logic            avail_cur;
    logic            avail_oth;

    logic            load;
    logic            load_start;
    logic            load_bank;
    logic [AW-1:0]   load_bin;
    logic            rd_byp;
    logic [AW-1:0]   rd_addr;
    logic [2*NB-1:0] rd_word;

    // Write FSM next state: a start sample always (re)opens the current bank at address 0.
    always_comb begin
        w_state_nx = w_state;
        wr_en      = 1'b0;
        wr_addr    = w_ptr;
        frame_done = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (in_valid_i && in_start_i) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    w_state_nx = W_FILL;
                end
            end
            W_FILL: begin
                if (in_valid_i) begin
                    wr_en = 1'b1;
                    if (in_start_i) begin
                        wr_addr = '0;
                    end else if (w_ptr == LAST) begin
                        frame_done = 1'b1;
                        w_state_nx = W_IDLE;
                    end
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nx;
        end
    end

    // Write pointer and bank; the bank flips once a full frame has landed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_ptr  <= '0;
            w_bank <= 1'b0;
        end else if (frame_done) begin
            w_ptr  <= '0;
            w_bank <= ~w_bank;
        end else if (wr_en) begin
            w_ptr <= wr_addr + AW'(1);
        end
    end

    // Sample storage; contents survive reset since every frame rewrites all entries.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[{w_bank, wr_addr}] <= {DR, DI};
        end
    end

`ifdef FFT_REORDER_BYPASS_EN
    logic [1:0] byp_q;

    // Per-bank bypass mode, captured with each frame's start sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            byp_q <= 2'b00;
        end else if (wr_en && in_start_i) begin
            byp_q[w_bank] <= bypass_i;
        end
    end

    assign rd_byp = byp_q[load_bank];
`else
    assign rd_byp = 1'b0;
`endif

    // Read FSM next state: a bank counts as available on the same cycle its last sample is written.
    always_comb begin
        r_state_nx = r_state;
        r_cnt_nx   = r_cnt;
        r_bank_nx  = r_bank;
        full_nx    = full;
        load       = 1'b0;
        load_start = 1'b0;
        load_bank  = r_bank;
        load_bin   = r_cnt + AW'(1);
        avail_cur  = full[r_bank]  | (frame_done & (w_bank == r_bank));
        avail_oth  = full[~r_bank] | (frame_done & (w_bank != r_bank));
        if (frame_done) begin
            full_nx[w_bank] = 1'b1;
        end
        case (r_state)
            R_IDLE: begin
                if (avail_cur) begin
                    load       = 1'b1;
                    load_start = 1'b1;
                    load_bin   = '0;
                    r_cnt_nx   = '0;
                    r_state_nx = R_READ;
                end
            end
            R_READ: begin
                if (r_cnt != LAST) begin
                    load     = 1'b1;
                    r_cnt_nx = r_cnt + AW'(1);
                end else begin
                    full_nx[r_bank] = 1'b0;
                    r_bank_nx       = ~r_bank;
                    if (avail_oth) begin
                        load       = 1'b1;
                        load_start = 1'b1;
                        load_bank  = ~r_bank;
                        load_bin   = '0;
                        r_cnt_nx   = '0;
                    end else begin
                        r_state_nx = R_IDLE;
                    end
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Read FSM state, bin counter, bank select and full flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_bank  <= 1'b0;
            full    <= 2'b00;
        end else begin
            r_state <= r_state_nx;
            r_cnt   <= r_cnt_nx;
            r_bank  <= r_bank_nx;
            full    <= full_nx;
        end
    end

    assign rd_addr = rd_byp ? load_bin : bitrev5(load_bin);
    assign rd_word = mem[{load_bank, rd_addr}];

    // Registered outputs; data holds its last value between frames.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_o <= 1'b0;
            out_start_o <= 1'b0;
            OR          <= '0;
            OI          <= '0;
        end else begin
            out_valid_o <= load;
            out_start_o <= load_start;
            if (load) begin
                OR <= rd_word[2*NB-1:NB];
                OI <= rd_word[NB-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - scoreboard bench for fft_out_reorder (honours FFT_REORDER_BYPASS_EN)
module tb_fft_out_reorder;

    localparam int NB = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid_i;
    logic          in_start_i;
    logic          byp;
    logic [NB-1:0] DR;
    logic [NB-1:0] DI;
    logic          out_valid_o;
    logic          out_start_o;
    logic [NB-1:0] OR;
    logic [NB-1:0] OI;

    fft_out_reorder #(.NB(NB), .NPT(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid_i (in_valid_i),
        .in_start_i (in_start_i),
`ifdef FFT_REORDER_BYPASS_EN
        .bypass_i   (byp),
`endif
        .DR         (DR),
        .DI         (DI),
        .out_valid_o(out_valid_o),
        .out_start_o(out_start_o),
        .OR         (OR),
        .OI         (OI)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            cyc;
        bit            st;
        logic [NB-1:0] r;
        logic [NB-1:0] i;
    } exp_t;

    exp_t              exp_q[$];
    logic [2*NB-1:0]   col[$];
    bit                m_act = 0;
    bit                m_byp = 0;
    int                last_done = 0;
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    int                run = 0;
    int                run_max = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rev5(input int j);
        int r = 0;
        for (int b = 0; b < 5; b++)
            if ((j & (1 << b)) != 0) r += 1 << (4 - b);
        return r;
    endfunction

    // Reference model: gather a frame, emit its 32 bins in natural order once complete.
    task automatic model_accept(input logic v, input logic s, input logic [NB-1:0] r, input logic [NB-1:0] i);
        exp_t e;
        if (v && s) begin
            col.delete();
            col.push_back({r, i});
            m_act = 1;
            m_byp = byp;
        end else if (v && m_act) begin
            col.push_back({r, i});
        end
        if (col.size() == 32) begin
            for (int j = 0; j < 32; j++) begin
                int idx;
                idx   = m_byp ? j : rev5(j);
                e.cyc = cyc + j;
                e.st  = (j == 0);
                e.r   = col[idx][2*NB-1:NB];
                e.i   = col[idx][NB-1:0];
                exp_q.push_back(e);
            end
            last_done = cyc;
            col.delete();
            m_act = 0;
        end
    endtask

    task automatic drive_cycle(input logic v, input logic s, input logic [NB-1:0] r, input logic [NB-1:0] i);
        in_valid_i = v;
        in_start_i = s;
        DR = r;
        DI = i;
        @(posedge CLK);
        #1;
        if (!RST) model_accept(v, s, r, i);
    endtask

    task automatic drive_idle();
        drive_cycle(1'b0, 1'b0, NB'($urandom), NB'($urandom));
    endtask

    // gap: 0 contiguous, 1 idle between samples, 2 random idles
    task automatic send_frame(input int br, input int bi, input bit rnd, input int gap);
        for (int i = 0; i < 32; i++) begin
            if (gap == 1 && i > 0) drive_idle();
            if (gap == 2) while ($urandom_range(0, 2) == 0) drive_idle();
            if (rnd) drive_cycle(1'b1, i == 0, NB'($urandom), NB'($urandom));
            else     drive_cycle(1'b1, i == 0, NB'(br + i), NB'(bi + i));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            drive_idle();
            n++;
        end
        repeat (3) drive_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d bins still expected, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every presented bin must match the head of the expected queue, at its cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (out_valid_o) begin
            run++;
            if (run > run_max) run_max = run;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got OR=%0h OI=%0h with nothing expected (cycle %0d)", OR, OI, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_cycle", 64'(cyc), 64'(e.cyc));
                chk("out_start", 64'(out_start_o), 64'(e.st));
                chk("out_OR", 64'(OR), 64'(e.r));
                chk("out_OI", 64'(OI), 64'(e.i));
            end
        end else begin
            run = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_out: out_valid_o=0, expected OR=%0h at cycle %0d", e.r, e.cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int target;
        RST = 1'b1;
        in_valid_i = 1'b0;
        in_start_i = 1'b0;
        DR = '0;
        DI = '0;
        byp = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_start", 64'(out_start_o), 64'd0);
        chk("rst_OR", 64'(OR), 64'd0);
        chk("rst_OI", 64'(OI), 64'd0);
        RST = 1'b0;

        // samples without start while idle are ignored
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, NB'($urandom), NB'($urandom));
        drive_idle();

        // single contiguous frame DR=i, DI=32+i
        send_frame(0, 32, 1'b0, 0);
        wait_drain();

        // three frames back-to-back
        run_max = 0;
        repeat (3) send_frame(0, 0, 1'b1, 0);
        wait_drain();
        chk("b2b_run", 64'(run_max), 64'd96);

        // valid low every other cycle
        send_frame(0, 32, 1'b0, 1);
        wait_drain();

        // restart at sample 10
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, i == 0, NB'(50 + i), NB'(60 + i));
        send_frame(100, 200, 1'b0, 0);
        wait_drain();

        // reset while bin 12 is on the output
        send_frame(0, 32, 1'b0, 0);
        target = last_done + 12;
        while (cyc < target) drive_idle();
        RST = 1'b1;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        col.delete();
        m_act = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_start", 64'(out_start_o), 64'd0);
        chk("mid_rst_OR", 64'(OR), 64'd0);
        chk("mid_rst_OI", 64'(OI), 64'd0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b0, NB'($urandom), NB'($urandom));
        repeat (20) drive_idle();
        send_frame(0, 0, 1'b1, 0);
        wait_drain();

        // random frames, random gaps, occasional aborted prefixes
        for (int f = 0; f < 5; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(1, 20);
                for (int i = 0; i < n; i++) drive_cycle(1'b1, i == 0, NB'($urandom), NB'($urandom));
            end
            send_frame(0, 0, 1'b1, 2);
        end
        wait_drain();

`ifdef FFT_REORDER_BYPASS_EN
        // bypass frame keeps input order
        byp = 1'b1;
        send_frame(0, 32, 1'b0, 0);
        byp = 1'b0;
        send_frame(0, 32, 1'b0, 0);
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter NB, default 16: width of one SFP real or imaginary word, carried through unchanged.
REQ-002 SHALL have parameter NPT, default 32: frame length in points, fixed at 32; address width 5.
REQ-003 SHALL have port CLK  input  1  clock; all logic rises on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid_i  input  1  DR/DI carry a valid FFT output sample this cycle.
REQ-006 SHALL have port in_start_i  input  1  qualifies sample 0 of a frame; only meaningful with in_valid_i.
REQ-007 SHALL have port DR  input  NB  real part, bit-reversed order from upstream FFT32.
REQ-008 SHALL have port DI  input  NB  imaginary part, same order.
REQ-009 SHALL have port out_valid_o  output  1  OR/OI valid.
REQ-010 SHALL have port out_start_o  output  1  marks output bin 0.
REQ-011 SHALL have port OR  output  NB  real part, natural order.
REQ-012 SHALL have port OI  output  NB  imaginary part, natural order.

Function
REQ-013 SHALL store samples in a ping-pong buffer: two banks of 32 entries of {DR,DI}; one bank written while the other is read.
REQ-014 SHALL run write FSM W_IDLE/W_FILL: W_IDLE->W_FILL on in_valid_i&in_start_i, writing that sample at address 0; in W_FILL each in_valid_i writes the next address.
REQ-015 SHALL, on write of address 31, mark the bank full, toggle the write bank and return to W_IDLE (frame complete).
REQ-016 SHALL ignore in_valid_i without in_start_i in W_IDLE; in_valid_i gaps in W_FILL stall the write pointer.
REQ-017 SHALL, on in_start_i&in_valid_i while in W_FILL, discard the partial frame and restart the same bank at address 0 with that sample.
REQ-018 SHALL run read FSM R_IDLE/R_READ: enter R_READ the cycle after a frame complete; output one bin per cycle, j=0..31, without gaps.
REQ-019 SHALL output bin j from stored address bitrev5(j) (e.g. j=1 -> addr 16, j=3 -> addr 24).
REQ-020 SHALL register outputs: last input sample accepted at cycle T gives out_valid_o=1, out_start_o=1, bin 0 at cycle T+1; bin 31 at T+32.
REQ-021 SHALL assert out_start_o only with bin 0 and out_valid_o only in R_READ; OR/OI hold last value when out_valid_o=0.
REQ-022 SHALL, when a new frame completes on the cycle bin 31 is output, continue with the new bank's bin 0 on the next cycle (back-to-back frames, no idle cycle).
REQ-023 SHALL never overflow: write rate ≤1/cycle guarantees a bank is drained before it is rewritten; no backpressure port.

Reset
REQ-024 SHALL, while RST=1 at a clock edge, force W_IDLE, R_IDLE, write bank 0, pointers 0, full flags 0, out_valid_o=0, out_start_o=0, OR=0, OI=0.
REQ-025 SHALL, on RST mid-frame or mid-read, abandon all frames; buffer RAM contents need not be cleared.

Configuration
REQ-026 SHALL, when macro FFT_REORDER_BYPASS_EN is defined, add input bypass_i (1 bit, sampled at each frame's in_start_i); bypass=1 reads bin j from address j (input order preserved, same latency).
REQ-027 SHALL, when FFT_REORDER_BYPASS_EN is undefined, have no bypass_i port and always bit-reverse.

Verification
REQ-028 SHALL cover: reset, one frame DR=i, DI=32+i for i=0..31 contiguous -> out_start_o at T+1, OR sequence 0,16,8,24,4,...,31, OI=OR+32.
REQ-029 SHALL cover: three frames back-to-back -> 96 consecutive out_valid_o cycles, out_start_o at bins 0 (cycles T+1, T+33, T+65).
REQ-030 SHALL cover: frame with in_valid_i low every other cycle -> output identical to REQ-028, starting cycle after 32nd valid sample.
REQ-031 SHALL cover: in_start_i at sample 10 of a frame, then 32 samples DR=100+i -> only one output frame, OR=100+bitrev5(j).
REQ-032 SHALL cover: RST=1 one cycle during bin 12 of output -> out_valid_o=0 next cycle, OR=OI=0, no further output until a new full frame.
REQ-033 SHALL cover, with FFT_REORDER_BYPASS_EN: bypass_i=1 at in_start_i, DR=i -> OR=0,1,2,...,31.
